// File: rtl/kv_store_responder_if.sv
// Client word-access bus between crypto wrappers (master) and the key vault (slave).
// Read responses arrive one cycle after the request. Write errors are reported one cycle after the write.
interface kv_store_responder_if #(
   parameter int ENTRY_W = 3,
   parameter int OFF_W   = 4
);
   logic               kv_rd_en;
   logic [ENTRY_W-1:0] kv_rd_entry;
   logic [OFF_W-1:0]   kv_rd_offset;
   logic               kv_rd_valid;
   logic [31:0]        kv_rd_data;
   logic               kv_rd_err;
   logic               kv_wr_en;
   logic [ENTRY_W-1:0] kv_wr_entry;
   logic [OFF_W-1:0]   kv_wr_offset;
   logic [31:0]        kv_wr_data;
   logic               kv_wr_last;
   logic               kv_wr_err;

   modport master (
      output kv_rd_en, kv_rd_entry, kv_rd_offset,
      output kv_wr_en, kv_wr_entry, kv_wr_offset, kv_wr_data, kv_wr_last,
      input  kv_rd_valid, kv_rd_data, kv_rd_err, kv_wr_err
   );

   modport slave (
      input  kv_rd_en, kv_rd_entry, kv_rd_offset,
      input  kv_wr_en, kv_wr_entry, kv_wr_offset, kv_wr_data, kv_wr_last,
      output kv_rd_valid, kv_rd_data, kv_rd_err, kv_wr_err
   );
endinterface

// File: rtl/kv_store_responder.sv
// Key-vault storage endpoint: word reads/writes with per-slot valid/lock and a firmware-triggered scrub.
// Slots locked by firmware stay readable but reject writes and scrubs until reset.
module kv_store_responder #(
   parameter  int NUM_ENTRIES  = 8,
   parameter  int ENTRY_DWORDS = 12,
   localparam int ENTRY_W      = $clog2(NUM_ENTRIES),
   localparam int OFF_W        = $clog2(ENTRY_DWORDS)
) (
   input  logic                   clk,
   input  logic                   reset,
   kv_store_responder_if.slave    kv,
   input  logic                   sw_clear_req,
   input  logic                   sw_lock_req,
   input  logic [ENTRY_W-1:0]     sw_entry,
   output logic                   clear_busy,
   output logic [NUM_ENTRIES-1:0] entry_valid,
   output logic [NUM_ENTRIES-1:0] entry_lock
);

   localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(ENTRY_DWORDS - 1);

   typedef enum logic [0:0] {IDLE, CLEAR} state_t;

   state_t               state_q, state_d;
   logic [31:0]          mem [NUM_ENTRIES][ENTRY_DWORDS];
   logic [NUM_ENTRIES-1:0] valid_q, lock_q;
   logic [ENTRY_W-1:0]   clr_slot_q;
   logic [OFF_W-1:0]     clr_cnt_q;
   logic                 rd_valid_q, rd_err_q, wr_err_q;
   logic [31:0]          rd_data_q;

   logic rd_err_c, wr_err_c, wr_ok, lock_ok, clr_start;

   // A slot is "under scrub" only once the FSM has latched it, not in the request cycle.
   always_comb begin
      rd_err_c = !valid_q[kv.kv_rd_entry] || (kv.kv_rd_offset > LAST_OFF) ||
                 ((state_q == CLEAR) && (kv.kv_rd_entry == clr_slot_q));
      wr_err_c = lock_q[kv.kv_wr_entry] || (kv.kv_wr_offset > LAST_OFF) ||
                 ((state_q == CLEAR) && (kv.kv_wr_entry == clr_slot_q));
      wr_ok    = kv.kv_wr_en && !wr_err_c;
      lock_ok  = sw_lock_req && !((state_q == CLEAR) && (sw_entry == clr_slot_q));
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every output of a combinational block gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_d   = state_q;
      clr_start = 1'b0;
      case (state_q)
         IDLE: begin
            // A same-cycle lock wins over the clear.
            if (sw_clear_req && !sw_lock_req && !lock_q[sw_entry]) begin
               state_d   = CLEAR;
               clr_start = 1'b1;
            end
         end
         CLEAR: begin
            if (clr_cnt_q == LAST_OFF) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: key storage is reset word by word so no key material survives a reset; this costs RAM inference on purpose.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int e = 0; e < NUM_ENTRIES; e++)
            for (int w = 0; w < ENTRY_DWORDS; w++)
               mem[e][w] <= '0;
         valid_q    <= '0;
         lock_q     <= '0;
         clr_slot_q <= '0;
         clr_cnt_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_data_q  <= '0;
         wr_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= kv.kv_rd_en;
         rd_err_q   <= kv.kv_rd_en && rd_err_c;
         rd_data_q  <= (kv.kv_rd_en && !rd_err_c) ? mem[kv.kv_rd_entry][kv.kv_rd_offset] : '0;
         wr_err_q   <= kv.kv_wr_en && wr_err_c;

         if (wr_ok) begin
            mem[kv.kv_wr_entry][kv.kv_wr_offset] <= kv.kv_wr_data;
            if (kv.kv_wr_offset == '0) valid_q[kv.kv_wr_entry] <= 1'b0;
            if (kv.kv_wr_last)         valid_q[kv.kv_wr_entry] <= 1'b1;
         end

         if (lock_ok) lock_q[sw_entry] <= 1'b1;

         // Scrub updates come last so they override a same-cycle client write.
         if (clr_start) begin
            clr_slot_q        <= sw_entry;
            clr_cnt_q         <= '0;
            valid_q[sw_entry] <= 1'b0;
         end else if (state_q == CLEAR) begin
            mem[clr_slot_q][clr_cnt_q] <= '0;
            clr_cnt_q                  <= clr_cnt_q + OFF_W'(1);
         end
      end
   end

   assign kv.kv_rd_valid = rd_valid_q;
   assign kv.kv_rd_err   = rd_err_q;
   assign kv.kv_rd_data  = rd_data_q;
   assign kv.kv_wr_err   = wr_err_q;
   assign clear_busy     = (state_q == CLEAR);
   assign entry_valid    = valid_q;
   assign entry_lock     = lock_q;

endmodule

// File: tb/tb_kv_store_responder.sv
// Directed bench for kv_store_responder: a vector table for plain reads/writes plus
// hand-written lock, collision, scrub and reset-mid-scrub sequences.
module tb_kv_store_responder;
   localparam int NE = 8;
   localparam int ED = 12;
   localparam int EW = 3;
   localparam int OW = 4;

   typedef struct {
      logic        is_wr;
      logic [EW-1:0] entry;
      logic [OW-1:0] offset;
      logic [31:0] data;
      logic        last;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          sw_clear_req, sw_lock_req;
   logic [EW-1:0] sw_entry;
   logic          clear_busy;
   logic [NE-1:0] entry_valid, entry_lock;

   int   tests = 0;
   int   failed = 0;
   vec_t vecs[$];

   kv_store_responder_if #(.ENTRY_W(EW), .OFF_W(OW)) kv ();

   kv_store_responder #(.NUM_ENTRIES(NE), .ENTRY_DWORDS(ED)) dut (
      .clk         (clk),
      .reset       (reset),
      .kv          (kv),
      .sw_clear_req(sw_clear_req),
      .sw_lock_req (sw_lock_req),
      .sw_entry    (sw_entry),
      .clear_busy  (clear_busy),
      .entry_valid (entry_valid),
      .entry_lock  (entry_lock)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      kv.kv_rd_en = 1'b0; kv.kv_rd_entry = '0; kv.kv_rd_offset = '0;
      kv.kv_wr_en = 1'b0; kv.kv_wr_entry = '0; kv.kv_wr_offset = '0;
      kv.kv_wr_data = '0; kv.kv_wr_last = 1'b0;
      sw_clear_req = 1'b0; sw_lock_req = 1'b0; sw_entry = '0;
   endtask

   // Advance one edge and land 1 time unit after it, where outputs are sampled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [EW-1:0] e, input logic [OW-1:0] o);
      kv.kv_rd_en = 1'b1; kv.kv_rd_entry = e; kv.kv_rd_offset = o;
   endtask

   task automatic set_wr(input logic [EW-1:0] e, input logic [OW-1:0] o,
                         input logic [31:0] d, input logic last);
      kv.kv_wr_en = 1'b1; kv.kv_wr_entry = e; kv.kv_wr_offset = o;
      kv.kv_wr_data = d; kv.kv_wr_last = last;
   endtask

   task automatic write_key(input logic [EW-1:0] e, input logic [31:0] base);
      for (int i = 0; i < ED; i++) begin
         set_wr(e, OW'(i), base + 32'(i), (i == ED - 1));
         step();
         idle_inputs();
      end
   endtask

   task automatic read_check(input string name, input logic [EW-1:0] e, input logic [OW-1:0] o,
                             input logic exp_err, input logic [31:0] exp_data);
      set_rd(e, o);
      step();
      idle_inputs();
      check({name, "_valid"}, 32'(kv.kv_rd_valid), 32'd1);
      check({name, "_err"},   32'(kv.kv_rd_err),   32'(exp_err));
      check({name, "_data"},  kv.kv_rd_data,       exp_data);
   endtask

   function automatic void add(input logic is_wr, input logic [EW-1:0] e, input logic [OW-1:0] o,
                               input logic [31:0] d, input logic last,
                               input logic exp_err, input logic [31:0] exp_data);
      vec_t v;
      v.is_wr = is_wr; v.entry = e; v.offset = o; v.data = d; v.last = last;
      v.exp_err = exp_err; v.exp_data = exp_data;
      vecs.push_back(v);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int busy;

      // Vector table: slot 1 = 0x0E+i, slot 2 = 0xA0+i, slot 4 = 0x40+i, slot 6 restarted.
      for (int i = 0; i < ED; i++) add(1'b1, 3'd1, OW'(i), 32'h0E + 32'(i), i == ED - 1, 1'b0, 32'h0);
      for (int i = 0; i < ED; i++) add(1'b1, 3'd2, OW'(i), 32'hA0 + 32'(i), i == ED - 1, 1'b0, 32'h0);
      for (int i = 0; i < ED; i++) add(1'b1, 3'd4, OW'(i), 32'h40 + 32'(i), i == ED - 1, 1'b0, 32'h0);
      for (int i = 0; i < ED; i++) add(1'b1, 3'd6, OW'(i), 32'h60 + 32'(i), i == ED - 1, 1'b0, 32'h0);
      add(1'b0, 3'd2, 4'd5,  '0, 1'b0, 1'b0, 32'hA5);
      add(1'b0, 3'd3, 4'd0,  '0, 1'b0, 1'b1, 32'h0);
      add(1'b0, 3'd2, 4'd12, '0, 1'b0, 1'b1, 32'h0);
      add(1'b0, 3'd1, 4'd3,  '0, 1'b0, 1'b0, 32'h11);
      add(1'b0, 3'd4, 4'd11, '0, 1'b0, 1'b0, 32'h4B);
      add(1'b0, 3'd6, 4'd2,  '0, 1'b0, 1'b0, 32'h62);
      add(1'b1, 3'd2, 4'd15, 32'hBAD, 1'b1, 1'b1, 32'h0);
      add(1'b1, 3'd3, 4'd13, 32'hBAD, 1'b1, 1'b1, 32'h0);
      add(1'b1, 3'd6, 4'd0,  32'h99, 1'b0, 1'b0, 32'h0);
      add(1'b0, 3'd6, 4'd1,  '0, 1'b0, 1'b1, 32'h0);

      // Reset state
      idle_inputs();
      reset = 1'b1;
      repeat (3) step();
      check("rst_rd_valid", 32'(kv.kv_rd_valid), 32'd0);
      check("rst_rd_err",   32'(kv.kv_rd_err),   32'd0);
      check("rst_rd_data",  kv.kv_rd_data,       32'd0);
      check("rst_wr_err",   32'(kv.kv_wr_err),   32'd0);
      check("rst_busy",     32'(clear_busy),     32'd0);
      check("rst_valid",    32'(entry_valid),    32'd0);
      check("rst_lock",     32'(entry_lock),     32'd0);
      reset = 1'b0;
      step();

      foreach (vecs[k]) begin
         if (vecs[k].is_wr) set_wr(vecs[k].entry, vecs[k].offset, vecs[k].data, vecs[k].last);
         else               set_rd(vecs[k].entry, vecs[k].offset);
         step();
         idle_inputs();
         if (vecs[k].is_wr) begin
            check($sformatf("vec%0d_wr_err", k), 32'(kv.kv_wr_err), 32'(vecs[k].exp_err));
            check($sformatf("vec%0d_rd_valid", k), 32'(kv.kv_rd_valid), 32'd0);
         end else begin
            check($sformatf("vec%0d_rd_valid", k), 32'(kv.kv_rd_valid), 32'd1);
            check($sformatf("vec%0d_rd_err", k),   32'(kv.kv_rd_err),   32'(vecs[k].exp_err));
            check($sformatf("vec%0d_rd_data", k),  kv.kv_rd_data,       vecs[k].exp_data);
         end
      end
      check("table_valid", 32'(entry_valid), 32'h16);

      // Lock slot 2: write rejected, data and valid kept, error not sticky, clear ignored
      sw_lock_req = 1'b1; sw_entry = 3'd2;
      step();
      idle_inputs();
      check("lock2", 32'(entry_lock), 32'h04);
      set_wr(3'd2, 4'd0, 32'hFF, 1'b0);
      step();
      idle_inputs();
      check("lock2_wr_err", 32'(kv.kv_wr_err), 32'd1);
      step();
      check("wr_err_not_sticky", 32'(kv.kv_wr_err), 32'd0);
      check("lock2_valid_kept", 32'(entry_valid[2]), 32'd1);
      read_check("lock2_rd", 3'd2, 4'd0, 1'b0, 32'hA0);
      sw_clear_req = 1'b1; sw_entry = 3'd2;
      step();
      idle_inputs();
      check("lock2_clear_ignored", 32'(clear_busy), 32'd0);

      // Same-cycle write and read of one word returns the old value
      set_wr(3'd1, 4'd3, 32'h55, 1'b0);
      set_rd(3'd1, 4'd3);
      step();
      idle_inputs();
      check("coll_rd_data", kv.kv_rd_data, 32'h11);
      check("coll_wr_err",  32'(kv.kv_wr_err), 32'd0);
      read_check("coll_after", 3'd1, 4'd3, 1'b0, 32'h55);

      // Same-cycle clear and lock: lock applied, clear ignored
      sw_clear_req = 1'b1; sw_lock_req = 1'b1; sw_entry = 3'd5;
      step();
      idle_inputs();
      check("clr_lock_busy", 32'(clear_busy), 32'd0);
      check("clr_lock_lock", 32'(entry_lock), 32'h24);

      // Scrub slot 4
      sw_clear_req = 1'b1; sw_entry = 3'd4;
      step();
      idle_inputs();
      check("scrub_valid4", 32'(entry_valid), 32'h06);
      busy = 0;
      for (int g = 0; g < 40 && clear_busy; g++) begin
         busy++;
         if (busy == 2) begin
            set_rd(3'd4, 4'd0);
            set_wr(3'd4, 4'd0, 32'hDEAD, 1'b1);
            step();
            idle_inputs();
            check("scrub_rd_err",  32'(kv.kv_rd_err), 32'd1);
            check("scrub_rd_data", kv.kv_rd_data,     32'd0);
            check("scrub_wr_err",  32'(kv.kv_wr_err), 32'd1);
         end else if (busy == 3) begin
            set_rd(3'd1, 4'd0);
            step();
            idle_inputs();
            check("scrub_other_err",  32'(kv.kv_rd_err), 32'd0);
            check("scrub_other_data", kv.kv_rd_data,     32'h0E);
         end else if (busy == 4) begin
            sw_lock_req = 1'b1; sw_entry = 3'd4;
            step();
            idle_inputs();
            check("scrub_lock_ignored", 32'(entry_lock), 32'h24);
         end else begin
            step();
         end
      end
      check("scrub_busy_cycles", busy, 32'd12);
      check("scrub_valid_after", 32'(entry_valid[4]), 32'd0);
      read_check("scrub_rd_after", 3'd4, 4'd0, 1'b1, 32'h0);
      write_key(3'd4, 32'h70);
      read_check("refill4", 3'd4, 4'd7, 1'b0, 32'h77);

      // Reset on scrub cycle 5
      sw_clear_req = 1'b1; sw_entry = 3'd1;
      step();
      idle_inputs();
      check("rst_scrub_start", 32'(clear_busy), 32'd1);
      repeat (4) step();
      check("rst_scrub_cycle5", 32'(clear_busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_busy",  32'(clear_busy),  32'd0);
      check("midrst_valid", 32'(entry_valid), 32'd0);
      check("midrst_lock",  32'(entry_lock),  32'd0);
      write_key(3'd2, 32'hC0);
      check("midrst_refill_valid", 32'(entry_valid), 32'h04);
      read_check("midrst_rd2", 3'd2, 4'd9, 1'b0, 32'hC9);
      read_check("midrst_rd1", 3'd1, 4'd3, 1'b1, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
